logic_unit_pipe: RTL
====================

# logic_unit_pipe

Parametrised, pipelined bitwise logic unit. It is the sequential successor to the single-bit gate block. It applies one of eight opcode-selected logic functions to WIDTH-bit operands, with an optional accumulator operand. Results pass through a STAGES-deep elastic pipeline with valid/ready handshakes on both sides. Each result carries reduction flags, and a counter tracks delivered results.

## Interface
Parameters:
- WIDTH, 8, operand and result width (1..64)
- STAGES, 2, number of pipeline register stages, i.e. latency (1..4)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit accepts the operation this cycle
- op  input  3  function select (encoding below)
- acc_sel  input  1  1: second operand is the accumulator instead of b
- acc_clr  input  1  clear the accumulator (see Operation)
- a  input  WIDTH  first operand
- b  input  WIDTH  second operand
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts the result
- y  output  WIDTH  result
- zero  output  1  y == 0
- parity  output  1  XOR-reduction of y
- ones  output  1  y is all ones
- op_count  output  16  number of output handshakes, wraps at 0xFFFF -> 0

## Operation
- Opcodes: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a.
- For NOT and PASS, the second operand is ignored.
- Second operand B:
  - B = 0 when acc_clr = 1.
  - Otherwise B = acc when acc_sel = 1.
  - Otherwise B = b.
- Input handshake fires when in_valid && in_ready.
  - On the handshake, the result and its three flags are computed combinationally and loaded into stage 0.
  - acc also loads the result on the handshake, whether or not acc_sel = 1.
- acc_clr without a handshake sets acc to 0.
- With a handshake in the same cycle, acc_clr zeroes the operand and acc loads the result.
- Pipeline:
  - Each stage i holds {valid_i, result, flags}.
  - Stage i advances when valid_i && (stage i+1 empty or advancing).
  - The last stage advances on out_valid && out_ready.
  - Stage 0 is ready when it is empty or advancing, and in_ready equals that condition.
  - Full throughput: one operation per cycle with no bubbles while out_ready = 1.
- Outputs y, zero, parity and ones are driven directly from the last stage's registers. There is no combinational path from the a/b/op inputs to the outputs.
- The only combinational path is out_ready to in_ready, through the ready chain.
- Backpressure: while out_ready = 0, out_valid, y and the flags are held stable.
  - After the pipeline fills, in_ready = 0. No accepted operation is lost or duplicated.
- op_count increments by 1 on each output handshake.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - every valid_i = 0, so out_valid = 0
  - y = 0, zero = 0, parity = 0, ones = 0
  - acc = 0, op_count = 0
- in_ready is 1 from the first cycle after reset release.
- Latency: an operation accepted at edge N gives out_valid = 1 after edge N+STAGES-1, i.e. it is first observable in the cycle after edge N+STAGES-1.
  - With STAGES = 1, the result is visible in the cycle after acceptance.
- Capacity: STAGES results in flight. in_ready drops only when all stages are valid and the last stage is not draining.
- Simultaneous input and output handshakes on a full pipeline: both fire and occupancy is unchanged.
- Reset mid-operation discards all in-flight results and the accumulator. op_count returns to 0.

## Structure
- Package logic_unit_pkg holds:
  - the op_t enum (OP_AND=0 … OP_PASS=7)
  - the result/flags struct
  - the function computing result and flags from (op, a, B)
- Sub-module logic_pipe_stage: one elastic register stage (valid, data, ready in/out).
  - Instantiated STAGES times in a generate loop.
  - Data width covers WIDTH+3 bits.
- The top level contains the operand mux, the accumulator, the ready chain and op_count.

## Test plan
- Truth table, WIDTH=8, STAGES=2, out_ready=1:
  - Stimulus: a=0xF0, b=0xCC, each op 0..7.
  - Response: y=0xC0, 0xFC, 0x0F, 0x3F, 0x03, 0x3C, 0xC3, 0xF0, each 2 cycles after acceptance.
  - Flags for AND: zero=0, parity=0, ones=0.
- Accumulate, acc_sel=1, op=XOR:
  - Stimulus: a=0x01, 0x02, 0x04 accepted back-to-back after acc_clr.
  - Response: y=0x01, 0x03, 0x07.
  - Then a=0x07 gives y=0x00 with zero=1 and parity=0.
- Backpressure:
  - Stimulus: hold out_ready=0 and stream 4 ops.
  - Response: in_ready=0 after 2 acceptances and y is held stable.
  - Release out_ready: all 4 results appear in order with no gaps, and op_count=4.
- Simultaneous handshakes, full pipeline, in_valid=out_ready=1 for 10 cycles:
  - Response: 10 accepted and 10 delivered.
  - in_ready stays 1 and op_count increments every cycle.
- acc_clr with acceptance:
  - Stimulus: acc=0x55, op=OR, acc_sel=1, a=0x80, acc_clr=1.
  - Response: y=0x80 and acc=0x80.
  - acc_clr alone afterwards sets acc=0.
- Reset mid-stream, with 2 results in flight and op_count=0xFFFF:
  - Stimulus: rst_n low for 1 cycle.
  - Response: out_valid=0, y=0, op_count=0, acc=0.
  - First op after release: y=b for op=OR with a=0.
  - Separately, one more handshake at op_count=0xFFFF wraps it to 0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pkg
//  Description : Opcode encoding, result/flag types and the combinational
//                logic function shared by the pipelined logic unit.
//  Revision    : 1.0  initial release
// ============================================================================
package logic_unit_pkg;

   localparam int unsigned MAX_W = 64;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NOT  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_t;

   typedef struct packed {
      logic zero;
      logic parity;
      logic ones;
   } flags_t;

   typedef struct packed {
      flags_t            flags;
      logic [MAX_W-1:0]  y;
   } lu_result_t;

   // Operands arrive zero-extended to MAX_W; bits above `width` are masked so
   // that the inverting functions cannot leak ones into the flag reductions.
   function automatic lu_result_t lu_compute(input op_t              op,
                                             input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int unsigned      width);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] r;
      lu_result_t       res;
      mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_NOT:  r = ~a;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XOR:  r = a ^ b;
         OP_XNOR: r = ~(a ^ b);
         default: r = a;
      endcase
      r                = r & mask;
      res.y            = r;
      res.flags.zero   = (r == '0);
      res.flags.parity = ^r;
      res.flags.ones   = ((r | ~mask) == '1);
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/logic_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module      : logic_pipe_stage
//  Description : One elastic register stage with valid/ready handshakes.
//                Accepts when empty or when its content is being taken.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_pipe_stage #(
   parameter int unsigned DW = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_i,
   output logic          ready_o,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] data_o
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q,  data_d;

   assign ready_o = !valid_q || ready_i;
   assign valid_o = valid_q;
   assign data_o  = data_q;

   // Next state: refill on a free slot, data only moves with a valid beat
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   // Stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_pipe
//  Description : Pipelined WIDTH-bit logic unit with accumulator operand,
//                STAGES-deep elastic pipeline, reduction flags and a
//                delivered-result counter.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_sel,
   input  logic             acc_clr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity,
   output logic             ones,
   output logic [15:0]      op_count
);

   localparam int unsigned DW = WIDTH + 3;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] w_b_opnd;
   lu_result_t       w_res;
   logic             w_in_fire;
   logic             w_out_fire;

   // Ready/valid chain: index 0 is the input side, index STAGES the output
   logic [STAGES:0]  w_valid;
   logic [STAGES:0]  w_ready;
   logic [DW-1:0]    w_data [0:STAGES];

   assign w_b_opnd   = acc_clr ? '0 : (acc_sel ? acc_q : b);
   assign w_res      = lu_compute(op_t'(op), 64'(a), 64'(w_b_opnd), WIDTH);
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;

   assign w_valid[0]      = in_valid;
   assign w_data[0]       = {w_res.flags, w_res.y[WIDTH-1:0]};
   assign in_ready        = w_ready[0];
   assign w_ready[STAGES] = out_ready;

   generate
      for (genvar i = 0; i < STAGES; i++) begin : g_stage
         logic_pipe_stage #(.DW(DW)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (w_valid[i]),
            .ready_o (w_ready[i]),
            .data_i  (w_data[i]),
            .valid_o (w_valid[i+1]),
            .ready_i (w_ready[i+1]),
            .data_o  (w_data[i+1])
         );
      end
   endgenerate

   assign out_valid             = w_valid[STAGES];
   assign y                     = w_data[STAGES][WIDTH-1:0];
   assign {zero, parity, ones}  = w_data[STAGES][DW-1 -: 3];
   assign op_count              = cnt_q;

   // Accumulator takes every accepted result; a lone clear zeroes it
   always_comb begin
      acc_d = acc_q;
      if (w_in_fire) begin
         acc_d = w_res.y[WIDTH-1:0];
      end else if (acc_clr) begin
         acc_d = '0;
      end
   end

   // Delivered-result counter, wraps naturally at 16 bits
   always_comb begin
      cnt_d = cnt_q;
      if (w_out_fire) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Accumulator and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire
